macrocell_cfg_loader: RTL and testbench

- Serial configuration controller that fills the mux-configuration bits of an array of macrocells from a bit stream.
- Accepts a framed, parity-protected serial stream under a valid/ready handshake. Deserialises one frame per macrocell and issues one parallel write per frame into the macrocell configuration register file.
- Sits between the device programming port and the macrocell array; sequences power-up and reprogramming.

---
 rtl/macrocell_cfg_loader.sv | 222 ++++++++++++++++++++++
 tb/tb_macrocell_cfg_loader.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/macrocell_cfg_loader.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// macrocell_cfg_loader
//
// Purpose:
//   Serial configuration controller for a macrocell array. It receives a
//   framed, even-parity-protected bit stream under a valid/ready handshake.
//   For each macrocell it deserialises one frame of CFG_BITS data bits
//   (LSB first) plus one parity bit. It then issues one parallel write into
//   the macrocell configuration register file. The write strobe appears the
//   cycle after the parity bit is accepted.
//
// Optional feature (macro CFG_CRC8_EN):
//   When the macro is defined, the loader checks an 8-bit CRC trailer after
//   the last frame. The trailer is sent MSB first. The CRC uses polynomial
//   0x07, init 0x00, no reflection and no final XOR. It covers every data
//   bit in arrival order; parity bits are excluded. When the macro is not
//   defined, the last write goes straight to DONE.
//
// Ports:
//   clk_v        in   clock, rising edge
//   rst_v        in   asynchronous active-high reset
//   start_v      in   begin a load (honoured in IDLE, DONE, ERROR)
//   abort_v      in   abandon the load in progress (wins over start_v)
//   sdi_v        in   serial data bit
//   sdi_valid_v  in   sdi_v is valid this cycle
//   sdi_ready_v  out  loader accepts a bit this cycle
//   cfg_wr_v     out  one-cycle write strobe
//   cfg_addr_v   out  macrocell index of the write (held between writes)
//   cfg_data_v   out  configuration word, bit 0 received first (held)
//   busy_v       out  load in progress
//   done_v       out  load completed successfully (level)
//   err_v        out  load failed (level)
// ---------------------------------------------------------------------------
module macrocell_cfg_loader #(
  parameter int NUM_MC   = 16,
  parameter int ADDR_W   = 4,
  parameter int CFG_BITS = 21
) (
  input  logic                clk_v,
  input  logic                rst_v,
  input  logic                start_v,
  input  logic                abort_v,
  input  logic                sdi_v,
  input  logic                sdi_valid_v,
  output logic                sdi_ready_v,
  output logic                cfg_wr_v,
  output logic [ADDR_W-1:0]   cfg_addr_v,
  output logic [CFG_BITS-1:0] cfg_data_v,
  output logic                busy_v,
  output logic                done_v,
  output logic                err_v
);

  // Counts data bits 0..CFG_BITS-1; the value CFG_BITS marks the parity bit.
  localparam int CNT_W = $clog2(CFG_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_WRITE,
    S_DONE,
    S_ERROR
`ifdef CFG_CRC8_EN
    , S_CRC
`endif
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [ADDR_W-1:0]   frame_cnt;
  logic [CFG_BITS-1:0] shift_reg;

  logic accept;
  logic last_frame;

  assign accept     = sdi_valid_v & sdi_ready_v;
  assign last_frame = (frame_cnt == ADDR_W'(NUM_MC - 1));

`ifdef CFG_CRC8_EN
  logic [7:0] crc_q;   // running CRC over accepted data bits
  logic [6:0] crc_rx;  // first seven trailer bits; the eighth is compared live

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction
`endif

  // Every status output is registered next to the state transition that
  // defines it. Outputs are therefore plain flops with no decode logic.
  always_ff @(posedge clk_v or posedge rst_v) begin
    if (rst_v) begin
      // NOTE: the shift register is reset like every other flop. A reset
      // load must not expose data left over from the previous load.
      state       <= S_IDLE;
      bit_cnt     <= '0;
      frame_cnt   <= '0;
      shift_reg   <= '0;
      sdi_ready_v <= 1'b0;
      cfg_wr_v    <= 1'b0;
      cfg_addr_v  <= '0;
      cfg_data_v  <= '0;
      busy_v      <= 1'b0;
      done_v      <= 1'b0;
      err_v       <= 1'b0;
`ifdef CFG_CRC8_EN
      crc_q       <= '0;
      crc_rx      <= '0;
`endif
    end else begin
      // NOTE: non-blocking throughout. Every branch below reads the values
      // from before this edge; that is what makes the strobe one cycle wide.
      cfg_wr_v <= 1'b0;

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_v && !abort_v) begin
            state       <= S_SHIFT;
            frame_cnt   <= '0;
            bit_cnt     <= '0;
            done_v      <= 1'b0;
            err_v       <= 1'b0;
            busy_v      <= 1'b1;
            sdi_ready_v <= 1'b1;
`ifdef CFG_CRC8_EN
            crc_q       <= '0;
`endif
          end
        end

        S_SHIFT: begin
          if (abort_v) begin
            state       <= S_IDLE;
            busy_v      <= 1'b0;
            sdi_ready_v <= 1'b0;
          end else if (accept) begin
            if (bit_cnt == CNT_W'(CFG_BITS)) begin
              // Parity bit: the XOR of the whole frame must be 0.
              sdi_ready_v <= 1'b0;
              if ((^shift_reg ^ sdi_v) == 1'b0) begin
                state      <= S_WRITE;
                cfg_wr_v   <= 1'b1;
                cfg_addr_v <= frame_cnt;
                cfg_data_v <= shift_reg;
              end else begin
                state  <= S_ERROR;
                busy_v <= 1'b0;
                err_v  <= 1'b1;
              end
            end else begin
              // Shift right so that the first bit ends up in bit 0 after
              // CFG_BITS shifts.
              shift_reg <= {sdi_v, shift_reg[CFG_BITS-1:1]};
              bit_cnt   <= bit_cnt + CNT_W'(1);
`ifdef CFG_CRC8_EN
              crc_q     <= crc8_step(crc_q, sdi_v);
`endif
            end
          end
        end

        S_WRITE: begin
          // The strobe for this cycle is already on the port. An abort only
          // stops what follows it.
          if (abort_v) begin
            state  <= S_IDLE;
            busy_v <= 1'b0;
          end else if (last_frame) begin
`ifdef CFG_CRC8_EN
            state       <= S_CRC;
            bit_cnt     <= '0;
            sdi_ready_v <= 1'b1;
`else
            state  <= S_DONE;
            busy_v <= 1'b0;
            done_v <= 1'b1;
`endif
          end else begin
            state       <= S_SHIFT;
            frame_cnt   <= frame_cnt + ADDR_W'(1);
            bit_cnt     <= '0;
            sdi_ready_v <= 1'b1;
          end
        end

`ifdef CFG_CRC8_EN
        S_CRC: begin
          if (abort_v) begin
            state       <= S_IDLE;
            busy_v      <= 1'b0;
            sdi_ready_v <= 1'b0;
          end else if (accept) begin
            if (bit_cnt == CNT_W'(7)) begin
              sdi_ready_v <= 1'b0;
              busy_v      <= 1'b0;
              if ({crc_rx, sdi_v} == crc_q) begin
                state  <= S_DONE;
                done_v <= 1'b1;
              end else begin
                state <= S_ERROR;
                err_v <= 1'b1;
              end
            end else begin
              crc_rx  <= {crc_rx[5:0], sdi_v};
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
`endif

        default: begin
          state       <= S_IDLE;
          busy_v      <= 1'b0;
          sdi_ready_v <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_macrocell_cfg_loader.sv
`timescale 1ns/1ps
// Self-checking bench for macrocell_cfg_loader. A behavioural load model is
// compared against the DUT on every negative clock edge. Directed loads
// finish with literal checks on the captured writes and status levels.
module tb_macrocell_cfg_loader;

  localparam int NUM_MC   = 16;
  localparam int ADDR_W   = 4;
  localparam int CFG_BITS = 21;

  logic                clk_v = 1'b0;
  logic                rst_v;
  logic                start_v;
  logic                abort_v;
  logic                sdi_v;
  logic                sdi_valid_v;
  logic                sdi_ready_v;
  logic                cfg_wr_v;
  logic [ADDR_W-1:0]   cfg_addr_v;
  logic [CFG_BITS-1:0] cfg_data_v;
  logic                busy_v;
  logic                done_v;
  logic                err_v;

  always #5 clk_v = ~clk_v;

  macrocell_cfg_loader #(
    .NUM_MC  (NUM_MC),
    .ADDR_W  (ADDR_W),
    .CFG_BITS(CFG_BITS)
  ) dut (
    .clk_v      (clk_v),
    .rst_v      (rst_v),
    .start_v    (start_v),
    .abort_v    (abort_v),
    .sdi_v      (sdi_v),
    .sdi_valid_v(sdi_valid_v),
    .sdi_ready_v(sdi_ready_v),
    .cfg_wr_v   (cfg_wr_v),
    .cfg_addr_v (cfg_addr_v),
    .cfg_data_v (cfg_data_v),
    .busy_v     (busy_v),
    .done_v     (done_v),
    .err_v      (err_v)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  function automatic logic [20:0] frame_word(input int n);
    return 21'((n * 32'h1111) & 32'h1FFFFF);
  endfunction

  // CRC of one full clean load, computed straight from the frame contents.
  function automatic logic [7:0] crc_of_load();
    logic [7:0]  c;
    logic [20:0] w;
    c = 8'h00;
    for (int n = 0; n < NUM_MC; n++) begin
      w = frame_word(n);
      for (int i = 0; i < CFG_BITS; i++) c = crc_step(c, w[i]);
    end
    return c;
  endfunction

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_SHIFT = 1, M_WRITE = 2, M_DONE = 3, M_ERR = 4, M_CRC = 5;

  int          m_st    = M_IDLE;
  int          m_bits  = 0;
  int          m_frame = 0;
  logic [20:0] m_word  = '0;
  logic [7:0]  m_crc   = '0;
  logic [7:0]  m_rx    = '0;
  logic [3:0]  m_addr  = '0;
  logic [20:0] m_data  = '0;

  int          n_wr = 0;
  logic [20:0] cap_data [NUM_MC];

  always @(negedge clk_v) begin
    if (rst_v) begin
      m_st = M_IDLE; m_bits = 0; m_frame = 0; m_word = '0;
      m_crc = '0; m_rx = '0; m_addr = '0; m_data = '0;
      check("rst_ready", sdi_ready_v, 0);
      check("rst_wr",    cfg_wr_v,    0);
      check("rst_addr",  cfg_addr_v,  0);
      check("rst_data",  cfg_data_v,  0);
      check("rst_busy",  busy_v,      0);
      check("rst_done",  done_v,      0);
      check("rst_err",   err_v,       0);
    end else begin
      check("ready", sdi_ready_v, (m_st == M_SHIFT || m_st == M_CRC) ? 1 : 0);
      check("busy",  busy_v, (m_st == M_SHIFT || m_st == M_WRITE || m_st == M_CRC) ? 1 : 0);
      check("done",  done_v, (m_st == M_DONE) ? 1 : 0);
      check("err",   err_v,  (m_st == M_ERR) ? 1 : 0);
      check("wr",    cfg_wr_v, (m_st == M_WRITE) ? 1 : 0);
      check("addr",  cfg_addr_v, m_addr);
      check("data",  cfg_data_v, m_data);
      if (cfg_wr_v) begin
        n_wr++;
        cap_data[cfg_addr_v] = cfg_data_v;
      end

      // Advance with the inputs the DUT will see at the next rising edge.
      case (m_st)
        M_IDLE, M_DONE, M_ERR: begin
          if (start_v && !abort_v) begin
            m_st = M_SHIFT; m_frame = 0; m_bits = 0; m_word = '0; m_crc = '0;
          end
        end
        M_SHIFT: begin
          if (abort_v) m_st = M_IDLE;
          else if (sdi_valid_v) begin
            if (m_bits < CFG_BITS) begin
              m_word[m_bits] = sdi_v;
              m_crc = crc_step(m_crc, sdi_v);
              m_bits++;
            end else if (((^m_word) ^ sdi_v) == 1'b0) begin
              m_st = M_WRITE; m_addr = 4'(m_frame); m_data = m_word;
            end else begin
              m_st = M_ERR;
            end
          end
        end
        M_WRITE: begin
          if (abort_v) m_st = M_IDLE;
          else if (m_frame == NUM_MC - 1) begin
`ifdef CFG_CRC8_EN
            m_st = M_CRC; m_bits = 0; m_rx = '0;
`else
            m_st = M_DONE;
`endif
          end else begin
            m_frame++; m_bits = 0; m_word = '0; m_st = M_SHIFT;
          end
        end
        M_CRC: begin
          if (abort_v) m_st = M_IDLE;
          else if (sdi_valid_v) begin
            m_rx = {m_rx[6:0], sdi_v};
            m_bits++;
            if (m_bits == 8) m_st = (m_rx == m_crc) ? M_DONE : M_ERR;
          end
        end
        default: m_st = M_IDLE;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_v);
    #1;
  endtask

  task automatic idle(input int n);
    sdi_valid_v = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    start_v = 1'b1;
    tick();
    start_v = 1'b0;
  endtask

  // Presents one bit and holds it until the handshake takes it. Optional
  // idle gap cycles with random data go before it.
  task automatic send_bit(input logic b, input int gap);
    logic r;
    int   waited;
    repeat (gap) begin
      sdi_valid_v = 1'b0;
      sdi_v = 1'($urandom_range(0, 1));
      tick();
    end
    sdi_valid_v = 1'b1;
    sdi_v = b;
    r = 1'b0;
    waited = 0;
    while (!r && waited < 50) begin
      @(negedge clk_v);
      r = sdi_ready_v;
      tick();
      waited++;
    end
    sdi_valid_v = 1'b0;
    check("bit_accepted", r, 1);
  endtask

  task automatic send_frame(input logic [20:0] w, input logic bad_par, input int gap);
    for (int i = 0; i < CFG_BITS; i++) send_bit(w[i], gap);
    send_bit((^w) ^ bad_par, gap);
  endtask

  // A full load. bad_frame >= 0 corrupts that frame's parity and stops the
  // stream there. crc_flip XORs into the trailer when the CRC is built in.
  task automatic send_load(input int bad_frame, input int gap, input logic [7:0] crc_flip);
    logic [7:0] c;
    for (int n = 0; n < NUM_MC; n++) begin
      send_frame(frame_word(n), (n == bad_frame), gap);
      if (n == bad_frame) return;
    end
`ifdef CFG_CRC8_EN
    c = crc_of_load() ^ crc_flip;
    for (int i = 7; i >= 0; i--) send_bit(c[i], gap);
`else
    c = crc_flip;
`endif
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_v = 1'b1; start_v = 1'b1; abort_v = 1'b0; sdi_v = 1'b1; sdi_valid_v = 1'b1;

    // Reset held with start and valid asserted.
    repeat (4) tick();
    start_v = 1'b0; sdi_valid_v = 1'b0;
    tick();
    rst_v = 1'b0;
    idle(3);
    check("reset_no_writes", n_wr, 0);
    check("reset_idle_busy", busy_v, 0);

    // Clean load, back-to-back bits.
    n_wr = 0;
    pulse_start();
    send_load(-1, 0, 8'h00);
    idle(3);
    check("clean_nwr",   n_wr, 16);
    check("clean_d0",    cap_data[0], 21'h00000);
    check("clean_d3",    cap_data[3], 21'h03333);
    check("clean_d15",   cap_data[15], 21'h0FFFF);
    check("clean_done",  done_v, 1);
    check("clean_busy",  busy_v, 0);
    check("clean_addr",  cfg_addr_v, 15);

    // Frame 3 parity inverted, then junk bits that must be ignored.
    n_wr = 0;
    pulse_start();
    send_load(3, 0, 8'h00);
    sdi_valid_v = 1'b1;
    for (int i = 0; i < 30; i++) begin
      sdi_v = 1'($urandom_range(0, 1));
      tick();
    end
    idle(2);
    check("perr_nwr",   n_wr, 3);
    check("perr_err",   err_v, 1);
    check("perr_ready", sdi_ready_v, 0);
    check("perr_data",  cfg_data_v, 21'h02222);

    // Restart out of ERROR, then a full clean load.
    n_wr = 0;
    pulse_start();
    check("restart_err_clr", err_v, 0);
    check("restart_busy",    busy_v, 1);
    send_load(-1, 0, 8'h00);
    idle(3);
    check("restart_nwr",  n_wr, 16);
    check("restart_done", done_v, 1);

    // Valid toggling every other cycle.
    n_wr = 0;
    for (int i = 0; i < NUM_MC; i++) cap_data[i] = '0;
    pulse_start();
    send_load(-1, 1, 8'h00);
    idle(3);
    check("toggle_nwr",  n_wr, 16);
    check("toggle_d7",   cap_data[7], 21'h07777);
    check("toggle_d12",  cap_data[12], 21'h0CCCC);
    check("toggle_done", done_v, 1);

    // Abort mid-frame 5; a start pulse during the load is ignored.
    n_wr = 0;
    pulse_start();
    for (int n = 0; n < 3; n++) send_frame(frame_word(n), 1'b0, 0);
    start_v = 1'b1;
    repeat (2) tick();
    start_v = 1'b0;
    check("busy_start_ignored", busy_v, 1);
    for (int n = 3; n < 5; n++) send_frame(frame_word(n), 1'b0, 0);
    for (int i = 0; i < 10; i++) send_bit(1'b1, 0);
    abort_v = 1'b1;
    tick();
    abort_v = 1'b0;
    idle(3);
    check("abort_nwr",   n_wr, 5);
    check("abort_busy",  busy_v, 0);
    check("abort_done",  done_v, 0);
    check("abort_err",   err_v, 0);
    check("abort_ready", sdi_ready_v, 0);

    // Reset mid-frame: immediate return to IDLE, no write.
    n_wr = 0;
    pulse_start();
    send_frame(frame_word(1), 1'b0, 0);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 0);
    rst_v = 1'b1;
    repeat (2) tick();
    rst_v = 1'b0;
    idle(3);
    check("midrst_nwr",  n_wr, 1);
    check("midrst_busy", busy_v, 0);

`ifdef CFG_CRC8_EN
    // Correct trailer after a reset-aborted load.
    n_wr = 0;
    pulse_start();
    send_load(-1, 0, 8'h00);
    idle(3);
    check("crc_ok_nwr",  n_wr, 16);
    check("crc_ok_done", done_v, 1);

    // Trailer with bit 0 flipped: all writes issued, then error.
    n_wr = 0;
    pulse_start();
    send_load(-1, 0, 8'h01);
    idle(3);
    check("crc_bad_nwr",  n_wr, 16);
    check("crc_bad_err",  err_v, 1);
    check("crc_bad_done", done_v, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
